// File: rtl/tstamp_capture_ahbl.sv
// Timestamp capture: 4 event channels -> pending -> timestamp FIFO, AHB-Lite regs.
// Define TSTAMP_GLITCH_FILTER_EN to add a 3-sample stability filter per channel.
module tstamp_capture_ahbl #(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       systime_i,
    input  logic [NUM_CH-1:0] evt_i,
    input  logic [31:0]       ahbl_haddr_i,
    input  logic [2:0]        ahbl_hburst_i,
    input  logic [2:0]        ahbl_hsize_i,
    input  logic [1:0]        ahbl_htrans_i,
    input  logic [31:0]       ahbl_hwdata_i,
    input  logic              ahbl_hready_i,
    input  logic              ahbl_hsel_i,
    input  logic              ahbl_hwrite_i,
    output logic [31:0]       ahbl_hrdata_o,
    output logic              ahbl_hreadyout_o,
    output logic              ahbl_hresp_o,
    output logic              int_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = 5;

    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_CTRL   = 8'h04;
    localparam logic [7:0] A_POP    = 8'h08;
    localparam logic [7:0] A_HEAD   = 8'h0C;
    localparam logic [7:0] A_CLEAR  = 8'h10;
    localparam logic [7:0] A_THRESH = 8'h14;

    logic [8:0]        ctrl;
    logic [4:0]        thresh;
    logic              ovf;
    logic [NUM_CH-1:0] en, pol;

    assign en  = ctrl[NUM_CH-1:0];
    assign pol = ctrl[2*NUM_CH-1:NUM_CH];

    // ---------------- event synchronisation and edge detect
    logic [NUM_CH-1:0] sync1, sync2, lvl, hist, det;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= evt_i;
            sync2 <= sync1;
        end
    end

`ifdef TSTAMP_GLITCH_FILTER_EN
    logic [NUM_CH-1:0] smp0, smp1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            smp0 <= '0;
            smp1 <= '0;
        end else begin
            smp0 <= sync2;
            smp1 <= smp0;
        end
    end

    // hist doubles as the filter state: it only follows three equal samples
    always_comb begin
        lvl = hist;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((sync2[i] == smp0[i]) && (smp0[i] == smp1[i])) begin
                lvl[i] = sync2[i];
            end
        end
    end
`else
    assign lvl = sync2;
`endif

    // history resets high: the inactive level of the reset (falling) polarity
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist <= '1;
            det  <= '0;
        end else begin
            hist <= lvl;
            det  <= (lvl & ~hist & pol) | (~lvl & hist & ~pol);
        end
    end

    // ---------------- AHB-Lite access tracking
    logic       acc, ph_v, ph_wr;
    logic [7:0] ph_addr;
    logic       wr_en, rd_en;

    assign acc = ahbl_hsel_i & ahbl_htrans_i[1] & ahbl_hready_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ph_v    <= 1'b0;
            ph_wr   <= 1'b0;
            ph_addr <= '0;
        end else if (ph_v) begin
            ph_v <= 1'b0;
        end else if (acc) begin
            ph_v    <= 1'b1;
            ph_wr   <= ahbl_hwrite_i;
            ph_addr <= ahbl_haddr_i[7:0];
        end
    end

    assign wr_en            = ph_v & ph_wr;
    assign rd_en            = ph_v & ~ph_wr;
    assign ahbl_hreadyout_o = ~ph_v;
    assign ahbl_hresp_o     = 1'b0;

    logic flush, clr_ovf;
    assign flush   = wr_en & (ph_addr == A_CLEAR) & ahbl_hwdata_i[0];
    assign clr_ovf = wr_en & (ph_addr == A_CLEAR) & ahbl_hwdata_i[1];

    // ---------------- pending bits and arbiter
    logic [NUM_CH-1:0] pend, pend_n, cap;
    logic [31:0]       ts_q [NUM_CH];
    logic              push_v, drop_evt;
    logic [1:0]        push_ch;

    assign cap      = det & en & ~pend;
    assign drop_evt = |(det & en & pend);

    always_comb begin
        push_v  = |pend;
        push_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) push_ch = 2'(i);
        end
    end

    always_comb begin
        pend_n = pend;
        if (push_v) pend_n[push_ch] = 1'b0;
        if (flush) pend_n = '0;
        pend_n = pend_n | cap;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
            for (int i = 0; i < NUM_CH; i++) ts_q[i] <= '0;
        end else begin
            pend <= pend_n;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap[i]) ts_q[i] <= systime_i;
            end
        end
    end

    // ---------------- timestamp FIFO
    logic [31:0]   mem_ts [FIFO_DEPTH];
    logic [1:0]    mem_ch [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] level;
    logic          empty, full, do_pop, push_ok, push_drop, ovf_set;

    assign empty     = (level == '0);
    assign full      = (level == LW'(FIFO_DEPTH));
    assign do_pop    = rd_en & (ph_addr == A_POP) & ~empty;
    assign push_ok   = push_v & ~flush & (~full | do_pop);
    assign push_drop = push_v & ~flush & full & ~do_pop;
    assign ovf_set   = push_drop | drop_evt;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_ts[wptr] <= ts_q[push_ch];
            mem_ch[wptr] <= push_ch;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            if (push_ok && !do_pop) level <= level + 1'b1;
            else if (!push_ok && do_pop) level <= level - 1'b1;
        end
    end

    // ---------------- registers, read data, interrupt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl   <= '0;
            thresh <= 5'd1;
            ovf    <= 1'b0;
        end else begin
            if (wr_en && ph_addr == A_CTRL) ctrl <= ahbl_hwdata_i[8:0];
            if (wr_en && ph_addr == A_THRESH) thresh <= ahbl_hwdata_i[4:0];
            if (clr_ovf) ovf <= 1'b0;
            if (ovf_set) ovf <= 1'b1;
        end
    end

    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (ph_addr)
            A_STATUS: rd_val = {21'b0, ovf, full, empty, 3'b0, level};
            A_CTRL:   rd_val = {23'b0, ctrl};
            A_POP:    rd_val = empty ? '0 : mem_ts[rptr];
            A_HEAD:   rd_val = empty ? '0 : {30'b0, mem_ch[rptr]};
            A_THRESH: rd_val = {27'b0, thresh};
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ahbl_hrdata_o <= '0;
            int_o         <= 1'b0;
        end else begin
            if (rd_en) ahbl_hrdata_o <= rd_val;
            else if (wr_en) ahbl_hrdata_o <= '0;
            int_o <= ctrl[8] & (((level >= thresh) & (thresh != '0)) | ovf);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ahbl_haddr_i[31:8], ahbl_hburst_i, ahbl_hsize_i,
                           ahbl_htrans_i[0], ahbl_hwdata_i[31:9]};

endmodule
